house_sequencer: RTL and testbench

Sequences the house (dealer) turn once the player stands: it repeatedly requests cards from the deck, accumulates the house total with soft-ace handling, and stops on stand threshold, bust, five-card limit or deck fault. It sits beside the main game controller, which hands over the dealt house total on `start` and takes back `house_sum`, `house_count` and `result` on `done`. While busy it owns the deck card handshake (`card_start`/`card_ready`/`card`).

---
 rtl/blackjack_pkg.sv | 28 ++
 rtl/card_points.sv | 24 ++
 rtl/house_sequencer.sv | 178 +++++++++++++++++
 tb/tb_house_sequencer.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/blackjack_pkg.sv
// Shared blackjack encodings: result codes, card codes, table limits and sequencer states.
package blackjack_pkg;

    typedef enum logic [1:0] {
        RES_STAND     = 2'b00,
        RES_BUST      = 2'b01,
        RES_FIVE_CARD = 2'b10,
        RES_DECK_ERR  = 2'b11
    } result_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EVAL,
        ST_REQ,
        ST_WAIT_LOW,
        ST_WAIT_HIGH,
        ST_ADD,
        ST_DONE
    } seq_state_t;

    localparam logic [3:0] CARD_ACE  = 4'd1;
    localparam logic [3:0] CARD_KING = 4'd13;

    localparam int BUST_LIMIT          = 21;
    localparam int DEF_STAND_THRESHOLD = 17;
    localparam int DEF_MAX_CARDS       = 5;

endpackage

// File: rtl/card_points.sv
// Card code to point value; an ace reports 11 with ace_high set so the caller may demote it to 1.
module card_points (
    input  logic [3:0] card,
    output logic [3:0] points,
    output logic       ace_high
);
    import blackjack_pkg::*;

    always_comb begin
        points   = 4'd0;
        ace_high = 1'b0;
        if (card == CARD_ACE) begin
            points   = 4'd11;
            ace_high = 1'b1;
        end else if (card > CARD_KING) begin
            points = 4'd0;
        end else if (card >= 4'd10) begin
            points = 4'd10;
        end else begin
            points = card;   // 2..9 pass through, 0 stays illegal
        end
    end

endmodule

// File: rtl/house_sequencer.sv
// Dealer turn sequencer: draws cards over the deck handshake until stand, bust,
// full hand or deck fault, then reports the final hand with a one-cycle done pulse.
module house_sequencer #(
    parameter int STAND_THRESHOLD = blackjack_pkg::DEF_STAND_THRESHOLD,
    parameter int BUST_LIMIT      = blackjack_pkg::BUST_LIMIT,
    parameter int MAX_CARDS       = blackjack_pkg::DEF_MAX_CARDS,
    parameter bit HIT_SOFT_17     = 1'b0,
    parameter int TIMEOUT_CYCLES  = 1024
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [5:0] house_sum_in,
    input  logic [2:0] house_count_in,
    input  logic       soft_in,
    input  logic       card_ready,
    input  logic [3:0] card,
    input  logic       card_overflow,
    output logic       card_start,
    output logic       busy,
    output logic       done,
    output logic [1:0] result,
    output logic [5:0] house_sum,
    output logic [2:0] house_count
);
    import blackjack_pkg::*;

    localparam logic [5:0]  BUST_V   = 6'(BUST_LIMIT);
    localparam logic [5:0]  STAND_V  = 6'(STAND_THRESHOLD);
    localparam logic [2:0]  MAX_V    = 3'(MAX_CARDS);
    localparam int          WD_W     = $clog2(TIMEOUT_CYCLES + 2);
    localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT_CYCLES);

    seq_state_t      state_reg, state_next;
    logic [5:0]      sum_reg, sum_next;
    logic [2:0]      count_reg, count_next;
    logic            soft_reg, soft_next;
    result_t         result_reg, result_next;
    logic [3:0]      card_reg, card_next;
    logic            card_start_reg, card_start_next;
    logic [WD_W-1:0] wd_reg, wd_next;

    logic [3:0] points;
    logic       ace_high;
    logic       use_high;
    logic [5:0] add_value;
    logic       hit_soft;
    logic       timeout;

    card_points u_card_points (
        .card     (card_reg),
        .points   (points),
        .ace_high (ace_high)
    );

    // An ace only counts high when that cannot bust the hand.
    assign use_high  = ace_high && ((sum_reg + 6'd11) <= BUST_V);
    assign add_value = (ace_high && !use_high) ? 6'd1 : {2'b00, points};
    assign hit_soft  = HIT_SOFT_17 && soft_reg && (sum_reg == STAND_V);
    assign timeout   = wd_reg > WD_LIMIT;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg      <= ST_IDLE;
            sum_reg        <= '0;
            count_reg      <= '0;
            soft_reg       <= 1'b0;
            result_reg     <= RES_STAND;
            card_reg       <= '0;
            card_start_reg <= 1'b0;
            wd_reg         <= '0;
        end else begin
            state_reg      <= state_next;
            sum_reg        <= sum_next;
            count_reg      <= count_next;
            soft_reg       <= soft_next;
            result_reg     <= result_next;
            card_reg       <= card_next;
            card_start_reg <= card_start_next;
            wd_reg         <= wd_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        sum_next        = sum_reg;
        count_next      = count_reg;
        soft_next       = soft_reg;
        result_next     = result_reg;
        card_next       = card_reg;
        card_start_next = card_start_reg;
        wd_next         = wd_reg;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    sum_next    = house_sum_in;
                    count_next  = house_count_in;
                    soft_next   = soft_in;
                    result_next = RES_STAND;
                    state_next  = ST_EVAL;
                end
            end
            ST_EVAL: begin
                if (sum_reg > BUST_V && soft_reg) begin
                    sum_next  = sum_reg - 6'd10;
                    soft_next = 1'b0;
                end else if (sum_reg > BUST_V) begin
                    result_next = RES_BUST;
                    state_next  = ST_DONE;
                end else if (count_reg == MAX_V) begin
                    result_next = RES_FIVE_CARD;
                    state_next  = ST_DONE;
                end else if (sum_reg >= STAND_V && !hit_soft) begin
                    result_next = RES_STAND;
                    state_next  = ST_DONE;
                end else if (card_overflow) begin
                    result_next = RES_DECK_ERR;
                    state_next  = ST_DONE;
                end else begin
                    state_next = ST_REQ;
                end
            end
            ST_REQ: begin
                if (card_ready) begin
                    card_start_next = 1'b1;
                    wd_next         = '0;
                    state_next      = ST_WAIT_LOW;
                end
            end
            ST_WAIT_LOW: begin
                wd_next = wd_reg + WD_W'(1);
                if (timeout) begin
                    card_start_next = 1'b0;
                    result_next     = RES_DECK_ERR;
                    state_next      = ST_DONE;
                end else if (!card_ready) begin
                    card_start_next = 1'b0;
                    state_next      = ST_WAIT_HIGH;
                end
            end
            ST_WAIT_HIGH: begin
                wd_next = wd_reg + WD_W'(1);
                if (timeout) begin
                    card_start_next = 1'b0;
                    result_next     = RES_DECK_ERR;
                    state_next      = ST_DONE;
                end else if (card_ready) begin
                    card_next  = card;
                    state_next = ST_ADD;
                end
            end
            ST_ADD: begin
                if (points == 4'd0) begin
                    result_next = RES_DECK_ERR;
                    state_next  = ST_DONE;
                end else begin
                    sum_next   = sum_reg + add_value;
                    count_next = count_reg + 3'd1;
                    soft_next  = soft_reg | use_high;
                    state_next = ST_EVAL;
                end
            end
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = (state_reg != ST_IDLE);
        done = (state_reg == ST_DONE);
    end

    assign card_start  = card_start_reg;
    assign result      = result_reg;
    assign house_sum   = sum_reg;
    assign house_count = count_reg;

endmodule

// File: tb/tb_house_sequencer.sv
// Scoreboard bench for house_sequencer: directed turns push expectations, a monitor checks each done.
module tb_house_sequencer;

    localparam int T_CYC = 32;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic [5:0] house_sum_in = '0;
    logic [2:0] house_count_in = '0;
    logic       soft_in = 1'b0;
    logic       card_ready;
    logic [3:0] card;
    logic       card_overflow = 1'b0;
    logic       card_start;
    logic       busy;
    logic       done;
    logic [1:0] result;
    logic [5:0] house_sum;
    logic [2:0] house_count;

    house_sequencer #(
        .HIT_SOFT_17    (1'b1),
        .TIMEOUT_CYCLES (T_CYC)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .house_sum_in   (house_sum_in),
        .house_count_in (house_count_in),
        .soft_in        (soft_in),
        .card_ready     (card_ready),
        .card           (card),
        .card_overflow  (card_overflow),
        .card_start     (card_start),
        .busy           (busy),
        .done           (done),
        .result         (result),
        .house_sum      (house_sum),
        .house_count    (house_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        string name;
        int    res;
        int    sum;
        int    cnt;
        int    pulses;
        int    lat_min;
        int    lat_max;
        int    t0;
    } exp_t;

    exp_t exp_q[$];
    int   deck_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   pulses = 0;
    int   idle_viol = 0;
    int   deck_delay = 1;
    bit   stall = 1'b0;
    logic prev_cs = 1'b0;

    task automatic check(input string nm, input int act, input int expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, expv);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Deck model: drops ready when a request is seen, returns the next queued card later.
    initial begin
        card_ready = 1'b1;
        card = 4'd0;
        forever begin
            @(negedge clk);
            if (card_start) begin
                card_ready = 1'b0;
                repeat (deck_delay) @(negedge clk);
                while (stall) @(negedge clk);
                card = (deck_q.size() > 0) ? 4'(deck_q.pop_front()) : 4'd5;
                card_ready = 1'b1;
            end
        end
    end

    // Monitor: counts request pulses and checks each finished turn against the scoreboard.
    always @(negedge clk) begin
        if (rst) begin
            if (card_start && !prev_cs) pulses++;
            if (card_start && !busy) idle_viol++;
            prev_cs = card_start;
            if (done) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    exp_t e;
                    int lat;
                    e = exp_q.pop_front();
                    lat = cyc - e.t0;
                    $display("turn %s: result=%0d sum=%0d count=%0d pulses=%0d latency=%0d",
                             e.name, result, house_sum, house_count, pulses, lat);
                    check({e.name, "_result"}, int'(result), e.res);
                    check({e.name, "_sum"}, int'(house_sum), e.sum);
                    check({e.name, "_count"}, int'(house_count), e.cnt);
                    check({e.name, "_pulses"}, pulses, e.pulses);
                    check({e.name, "_cs_at_done"}, int'(card_start), 0);
                    check({e.name, "_cs_idle"}, idle_viol, 0);
                    if (e.lat_min == e.lat_max)
                        check({e.name, "_latency"}, lat, e.lat_min);
                    else
                        check({e.name, "_latency_in_range"},
                              int'(lat >= e.lat_min && lat <= e.lat_max), 1);
                end
            end
        end else begin
            prev_cs = 1'b0;
        end
    end

    task automatic run_turn(input string name, input int s, input int c, input bit sft,
                            input int d, input bit glitch, input int e_res, input int e_sum,
                            input int e_cnt, input int e_pul, input int lmin, input int lmax);
        exp_t e;
        bit seen;
        @(negedge clk);
        deck_delay = d;
        pulses = 0;
        e.name = name; e.res = e_res; e.sum = e_sum; e.cnt = e_cnt;
        e.pulses = e_pul; e.lat_min = lmin; e.lat_max = lmax; e.t0 = cyc;
        exp_q.push_back(e);
        start = 1'b1;
        house_sum_in = 6'(s);
        house_count_in = 3'(c);
        soft_in = sft;
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            start = glitch && (i == 2);
            house_sum_in = start ? 6'd30 : 6'd0;
            house_count_in = 3'd0;
            soft_in = 1'b0;
            if (done) seen = 1'b1;
        end
        if (!seen) begin
            check({name, "_done_seen"}, 0, 1);
            void'(exp_q.pop_front());
        end
        for (int i = 0; i < 100 && !card_ready; i++) @(negedge clk);
        if (!card_ready) check({name, "_deck_idle"}, 0, 1);
    endtask

    initial begin
        bit seen;
        repeat (3) @(negedge clk);
        check("rst_done", int'(done), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_card_start", int'(card_start), 0);
        check("rst_result", int'(result), 0);
        check("rst_sum", int'(house_sum), 0);
        check("rst_count", int'(house_count), 0);
        rst = 1'b1;

        run_turn("stand18", 18, 2, 0, 1, 0, 0, 18, 2, 0, 2, 2);
        deck_q = '{5};
        run_turn("hit5", 12, 2, 0, 3, 0, 0, 17, 3, 1, 9, 9);
        deck_q = '{13};
        run_turn("bust", 16, 2, 0, 1, 0, 1, 26, 3, 1, 7, 7);
        deck_q = '{6, 4};
        run_turn("soft17", 17, 2, 1, 1, 0, 0, 17, 4, 2, 13, 13);
        deck_q = '{2, 2, 3};
        run_turn("five", 4, 2, 0, 1, 1, 2, 11, 5, 3, 17, 17);
        deck_q = '{1, 10, 3};
        run_turn("ace", 5, 1, 0, 1, 0, 0, 19, 4, 3, 18, 18);
        deck_q = '{14};
        run_turn("badcard", 12, 2, 0, 1, 0, 3, 12, 2, 1, 6, 6);
        card_overflow = 1'b1;
        run_turn("overflow", 12, 2, 0, 1, 0, 3, 12, 2, 0, 2, 2);
        card_overflow = 1'b0;

        // Deck never returns a card: the watchdog must end the turn.
        deck_q = '{};
        stall = 1'b1;
        fork
            begin
                #(T_CYC * 10 + 100);
                stall = 1'b0;
            end
            run_turn("timeout", 12, 2, 0, 1, 0, 3, 12, 2, 1, T_CYC + 2, T_CYC + 8);
        join_any
        stall = 1'b0;
        for (int i = 0; i < 100 && !card_ready; i++) @(negedge clk);

        // Asynchronous reset mid-turn while waiting for the card.
        @(negedge clk);
        deck_delay = 20;
        pulses = 0;
        start = 1'b1;
        house_sum_in = 6'd12;
        house_count_in = 3'd2;
        @(negedge clk);
        start = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (card_start) seen = 1'b1;
        end
        check("rstwh_request_seen", int'(seen), 1);
        for (int i = 0; i < 20 && card_start; i++) @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("rstwh_card_start", int'(card_start), 0);
        check("rstwh_busy", int'(busy), 0);
        check("rstwh_done", int'(done), 0);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 100 && !card_ready; i++) @(negedge clk);

        run_turn("after_rst", 18, 2, 0, 1, 0, 0, 18, 2, 0, 2, 2);

        repeat (3) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
